// File: rtl/food_eat_ctrl.sv
// -----------------------------------------------------------------------------
// food_eat_ctrl
// Consumer side of the food-box generator. Requests a candidate box with a
// one-cycle drive pulse and lets the generator settle. It then checks the box
// against the playfield bounds and the snake head. An illegal box is requested
// again, up to MAX_RETRY times, after which a fixed fallback position is used.
// The accepted food is held until the head lands on it during a move tick.
// That eat bumps a saturating score and immediately starts the next request.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst        in   1        synchronous active-high reset
//   game_en    in   1        enables eat detection (refills always proceed)
//   tick       in   1        one-cycle pulse per snake move step
//   head_x/y   in   10       snake head position
//   box_x/y    in   10       candidate food position from the generator
//   drive      out  1        one-cycle request pulse to the generator
//   food_x/y   out  10       accepted food position
//   food_valid out  1        food_x/food_y are valid and eatable
//   eat_pulse  out  1        one-cycle pulse when the food is eaten
//   score      out  SCORE_W  foods eaten, saturating at all-ones
// -----------------------------------------------------------------------------
module food_eat_ctrl #(
  parameter logic [3:0] SETTLE    = 4'd4,
  parameter logic [3:0] MAX_RETRY = 4'd15,
  parameter logic [9:0] X_MAX     = 10'd630,
  parameter logic [9:0] Y_MAX     = 10'd470,
  parameter logic [9:0] FALL_X    = 10'd320,
  parameter logic [9:0] FALL_Y    = 10'd240,
  parameter int         SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic               tick,
  input  logic [9:0]         head_x,
  input  logic [9:0]         head_y,
  input  logic [9:0]         box_x,
  input  logic [9:0]         box_y,
  output logic               drive,
  output logic [9:0]         food_x,
  output logic [9:0]         food_y,
  output logic               food_valid,
  output logic               eat_pulse,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] retry_cnt;

  logic box_in_field;
  logic box_on_head;
  logic box_legal;
  logic head_on_food;
  logic eat_now;

  // All comparisons are unsigned 10-bit.
  assign box_in_field = (box_x <= X_MAX) && (box_y <= Y_MAX);
  assign box_on_head  = (box_x == head_x) && (box_y == head_y);
  assign box_legal    = box_in_field && !box_on_head;
  assign head_on_food = (head_x == food_x) && (head_y == food_y);
  assign eat_now      = tick && game_en && head_on_food;

  // The request pulse is a pure decode of the registered state, so it is high
  // for exactly the single cycle spent in REQ.
  assign drive = (state == REQ);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous; every register, including the held food
      // coordinates, returns to a known value so a reset mid-request abandons it.
      state      <= INIT;
      wait_cnt   <= 4'd0;
      retry_cnt  <= 4'd0;
      food_x     <= 10'd0;
      food_y     <= 10'd0;
      food_valid <= 1'b0;
      eat_pulse  <= 1'b0;
      score      <= '0;
    end else begin
      eat_pulse <= 1'b0;

      case (state)
        INIT: begin
          state <= REQ;
        end

        REQ: begin
          wait_cnt <= SETTLE;
          state    <= WAIT;
        end

        // Counting down from SETTLE and leaving when the count hits zero gives
        // exactly SETTLE cycles in WAIT.
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= CHECK;
          end
        end

        CHECK: begin
          if (box_legal) begin
            food_x     <= box_x;
            food_y     <= box_y;
            food_valid <= 1'b1;
            retry_cnt  <= 4'd0;
            state      <= HOLD;
          end else if (retry_cnt < MAX_RETRY) begin
            retry_cnt <= retry_cnt + 4'd1;
            state     <= REQ;
          end else begin
            // Retries exhausted: the fallback is accepted without checking it.
            food_x     <= FALL_X;
            food_y     <= FALL_Y;
            food_valid <= 1'b1;
            retry_cnt  <= 4'd0;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (eat_now) begin
            eat_pulse  <= 1'b1;
            food_valid <= 1'b0;
            if (score != '1) begin
              score <= score + 1'b1;
            end
            state <= REQ;
          end
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_eat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_food_eat_ctrl
// Directed bench for food_eat_ctrl. The score counter is narrowed to 4 bits so
// saturation is reachable in a short run; all other parameters are defaults.
// -----------------------------------------------------------------------------
module tb_food_eat_ctrl;

  localparam int         SCORE_W = 4;
  localparam logic [3:0] SCORE_MAX = 4'hF;

  logic               clk;
  logic               rst;
  logic               game_en;
  logic               tick;
  logic [9:0]         head_x;
  logic [9:0]         head_y;
  logic [9:0]         box_x;
  logic [9:0]         box_y;
  logic               drive;
  logic [9:0]         food_x;
  logic [9:0]         food_y;
  logic               food_valid;
  logic               eat_pulse;
  logic [SCORE_W-1:0] score;

  int n_vec;
  int n_err;
  int drive_cnt;
  int base;

  // Bench-side model of the held food and the score.
  logic [9:0] fx;
  logic [9:0] fy;
  logic [3:0] sc;

  food_eat_ctrl #(
    .SETTLE    (4'd4),
    .MAX_RETRY (4'd15),
    .X_MAX     (10'd630),
    .Y_MAX     (10'd470),
    .FALL_X    (10'd320),
    .FALL_Y    (10'd240),
    .SCORE_W   (SCORE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_en    (game_en),
    .tick       (tick),
    .head_x     (head_x),
    .head_y     (head_y),
    .box_x      (box_x),
    .box_y      (box_y),
    .drive      (drive),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .eat_pulse  (eat_pulse),
    .score      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive pulses are counted independently of the stimulus.
  initial drive_cnt = 0;
  always @(negedge clk) begin
    if (drive === 1'b1) drive_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after
  // the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc);
    int k;
    k = 0;
    while (food_valid !== 1'b1 && k < max_cyc) begin
      step();
      k++;
    end
    check("valid_wait", 32'(food_valid), 32'd1);
  endtask

  // Release reset with box=(100,200), head=(0,0) and check the cycle-exact
  // start-up: drive only in cycle 2, food_valid from cycle SETTLE+4 = 8.
  task automatic release_and_check_t1();
    box_x = 10'd100; box_y = 10'd200;
    head_x = 10'd0;  head_y = 10'd0;
    rst = 1'b0;
    check("t1_drive_c1", 32'(drive), 32'd0);
    for (int cyc = 2; cyc <= 8; cyc++) begin
      step();
      check($sformatf("t1_drive_c%0d", cyc), 32'(drive), (cyc == 2) ? 32'd1 : 32'd0);
      check($sformatf("t1_valid_c%0d", cyc), 32'(food_valid), (cyc >= 8) ? 32'd1 : 32'd0);
    end
    check("t1_food_x", 32'(food_x), 32'd100);
    check("t1_food_y", 32'(food_y), 32'd200);
    check("t1_eat", 32'(eat_pulse), 32'd0);
    check("t1_score", 32'(score), 32'd0);
    fx = 10'd100; fy = 10'd200; sc = 4'd0;
  endtask

  // Head steps onto the held food during a tick with game_en=1; the next food
  // comes from box (nx,ny), which must differ from the current head.
  task automatic eat(input logic [9:0] nx, input logic [9:0] ny);
    head_x = fx; head_y = fy;
    box_x = nx;  box_y = ny;
    game_en = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    sc = (sc == SCORE_MAX) ? SCORE_MAX : sc + 4'd1;
    check("eat_pulse", 32'(eat_pulse), 32'd1);
    check("eat_drive", 32'(drive), 32'd1);
    check("eat_valid", 32'(food_valid), 32'd0);
    check("eat_score", 32'(score), 32'(sc));
    step();
    check("eat_pulse_end", 32'(eat_pulse), 32'd0);
    wait_valid(40);
    check("eat_food_x", 32'(food_x), 32'(nx));
    check("eat_food_y", 32'(food_y), 32'(ny));
    fx = nx; fy = ny;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    game_en = 1'b0;
    tick = 1'b0;
    head_x = 10'd0; head_y = 10'd0;
    box_x = 10'd100; box_y = 10'd200;
    step();
    step();

    // Reset state
    check("rst_drive", 32'(drive), 32'd0);
    check("rst_food_x", 32'(food_x), 32'd0);
    check("rst_food_y", 32'(food_y), 32'd0);
    check("rst_valid", 32'(food_valid), 32'd0);
    check("rst_eat", 32'(eat_pulse), 32'd0);
    check("rst_score", 32'(score), 32'd0);

    // T1: start-up timing
    release_and_check_t1();

    // T5: head on food but game_en=0: ticks never eat
    head_x = 10'd100; head_y = 10'd200;
    game_en = 1'b0;
    base = drive_cnt;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("t5_eat", 32'(eat_pulse), 32'd0);
      check("t5_valid", 32'(food_valid), 32'd1);
      step();
    end
    check("t5_score", 32'(score), 32'd0);
    check("t5_drives", 32'(drive_cnt - base), 32'd0);

    // T4 + T2: eat with game_en=1; the refill first sees an out-of-field box
    box_x = 10'd700; box_y = 10'd50;
    game_en = 1'b1;
    base = drive_cnt;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t4_eat", 32'(eat_pulse), 32'd1);
    check("t4_drive", 32'(drive), 32'd1);
    check("t4_valid", 32'(food_valid), 32'd0);
    check("t4_score", 32'(score), 32'd1);
    step();
    check("t4_eat_end", 32'(eat_pulse), 32'd0);
    // Eat cycle e is REQ; CHECK is e+5, re-request at e+6.
    for (int i = 0; i < 5; i++) step();
    check("t2_redrive", 32'(drive), 32'd1);
    box_x = 10'd50; box_y = 10'd50;
    wait_valid(40);
    check("t2_drives", 32'(drive_cnt - base), 32'd2);
    check("t2_food_x", 32'(food_x), 32'd50);
    check("t2_food_y", 32'(food_y), 32'd50);
    check("t2_retry", 32'(dut.retry_cnt), 32'd0);
    fx = 10'd50; fy = 10'd50; sc = 4'd1;

    // T3: every candidate sits on the head -> fallback after 16 requests
    head_x = fx; head_y = fy;
    tick = 1'b1;
    step();
    tick = 1'b0;
    sc = 4'd2;
    check("t3_eat", 32'(eat_pulse), 32'd1);
    base = drive_cnt;
    head_x = 10'd40; head_y = 10'd40;
    box_x = 10'd40;  box_y = 10'd40;
    wait_valid(200);
    check("t3_drives", 32'(drive_cnt - base), 32'd16);
    check("t3_food_x", 32'(food_x), 32'd320);
    check("t3_food_y", 32'(food_y), 32'd240);
    check("t3_retry", 32'(dut.retry_cnt), 32'd0);
    for (int i = 0; i < 20; i++) step();
    check("t3_no_more_drive", 32'(drive_cnt - base), 32'd16);
    check("t3_valid_held", 32'(food_valid), 32'd1);
    fx = 10'd320; fy = 10'd240;

    // T6: drive score to all-ones, then one more eat must not wrap
    while (sc != SCORE_MAX) begin
      if (sc[0]) eat(10'd10, 10'd20);
      else       eat(10'd30, 10'd40);
    end
    check("t6_score_max", 32'(score), 32'(SCORE_MAX));
    eat(fx == 10'd10 ? 10'd30 : 10'd10, fx == 10'd10 ? 10'd40 : 10'd20);
    check("t6_score_sat", 32'(score), 32'(SCORE_MAX));

    // T6: reset asserted while waiting for the generator
    head_x = fx; head_y = fy;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    check("t6_in_wait", 32'(dut.state), 32'd2);
    rst = 1'b1;
    step();
    check("t6_rst_drive", 32'(drive), 32'd0);
    check("t6_rst_food_x", 32'(food_x), 32'd0);
    check("t6_rst_food_y", 32'(food_y), 32'd0);
    check("t6_rst_valid", 32'(food_valid), 32'd0);
    check("t6_rst_eat", 32'(eat_pulse), 32'd0);
    check("t6_rst_score", 32'(score), 32'd0);
    release_and_check_t1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
